int_wb_arbiter: RTL

Integer writeback arbiter, directly downstream of the integer FUs (ALU, MDU, branch). Each cycle it collects the registered writeback requests (`o_wb_vld`/`o_wbInfo`) from `NUM_FU` units and grants up to `NUM_WBPORT` of them round-robin. Granted results are registered onto the physical regfile write ports and the ROB completion bus. Ungranted FUs see `i_wb_stall` in the same cycle and hold their pipeline.

---
 rtl/int_wb_arbiter_pkg.sv | 28 ++
 rtl/int_wb_arbiter_if.sv | 27 ++
 rtl/int_wb_arbiter_rr_picker.sv | 42 ++++
 rtl/int_wb_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/int_wb_arbiter_pkg.sv
// Shared integer-cluster writeback types: payload struct, cluster defaults, FU index width.
// Pure declarations; no timing or flow control of its own.
package int_wb_arbiter_pkg;

  localparam int ROB_IDX_W      = 6;
  localparam int IROB_IDX_W     = 5;
  localparam int PRF_IDX_W      = 7;
  localparam int XLEN           = 64;
  localparam int INT_NUM_FU     = 4;
  localparam int INT_NUM_WBPORT = 2;

  typedef logic [$clog2(INT_NUM_FU)-1:0] fu_idx_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [IROB_IDX_W-1:0] irob_idx;
    logic                  use_imm;
    logic                  rd_wen;
    logic [PRF_IDX_W-1:0]  iprd_idx;
    logic [XLEN-1:0]       result;
  } valwbInfo_t;

  // Modular index step used for the round-robin scan and pointer advance.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/int_wb_arbiter_if.sv
// FU-to-writeback bundle: per-FU requests/payloads/stalls and registered write ports.
// Stall is the only backpressure; FUs hold their request while it is high.
interface int_wb_arbiter_if #(
  parameter int NUM_FU     = int_wb_arbiter_pkg::INT_NUM_FU,
  parameter int NUM_WBPORT = int_wb_arbiter_pkg::INT_NUM_WBPORT,
  parameter int CNT_W      = 32
);
  import int_wb_arbiter_pkg::*;

  logic [NUM_FU-1:0]     i_fu_wb_vld;
  valwbInfo_t            i_fu_wbInfo [NUM_FU];
  logic [NUM_FU-1:0]     o_fu_wb_stall;
  logic [NUM_WBPORT-1:0] o_wb_vld;
  valwbInfo_t            o_wbInfo [NUM_WBPORT];
  logic [CNT_W-1:0]      o_conflict_cnt;

  modport master (
    output i_fu_wb_vld, i_fu_wbInfo,
    input  o_fu_wb_stall, o_wb_vld, o_wbInfo, o_conflict_cnt
  );

  modport slave (
    input  i_fu_wb_vld, i_fu_wbInfo,
    output o_fu_wb_stall, o_wb_vld, o_wbInfo, o_conflict_cnt
  );

endinterface

// File: rtl/int_wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first NUM_WBPORT requests from i_ptr, k-th grant -> port k.
// Zero latency; no state, no backpressure of its own.
module wb_rr_picker import int_wb_arbiter_pkg::*; #(
  parameter int NUM_FU     = INT_NUM_FU,
  parameter int NUM_WBPORT = INT_NUM_WBPORT,
  parameter int IW         = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]     i_req,
  input  logic [IW-1:0]         i_ptr,
  output logic [NUM_FU-1:0]     o_grant,
  output logic [NUM_WBPORT-1:0] o_port_vld,
  output logic [IW-1:0]         o_port_idx [NUM_WBPORT],
  output logic [IW-1:0]         o_last_idx
);

  int            w_ngrant;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant    = '0;
    o_port_vld = '0;
    o_last_idx = '0;
    w_ngrant   = 0;
    w_idx      = '0;
    for (int k = 0; k < NUM_WBPORT; k++) o_port_idx[k] = '0;
    for (int s = 0; s < NUM_FU; s++) begin
      w_idx = IW'(wrap_add(int'(i_ptr), s, NUM_FU));
      if (i_req[w_idx] && (w_ngrant < NUM_WBPORT)) begin
        o_grant[w_idx] = 1'b1;
        for (int k = 0; k < NUM_WBPORT; k++) begin
          if (k == w_ngrant) begin
            o_port_vld[k] = 1'b1;
            o_port_idx[k] = w_idx;
          end
        end
        o_last_idx = w_idx;
        w_ngrant   = w_ngrant + 1;
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: round-robin grant of FU results onto registered write ports, 1-cycle latency.
// Losers get a combinational stall and must re-present next cycle; nothing is buffered here.
module int_wb_arbiter import int_wb_arbiter_pkg::*; #(
  parameter int NUM_FU     = INT_NUM_FU,
  parameter int NUM_WBPORT = INT_NUM_WBPORT,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  int_wb_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_FU);

  logic [IW-1:0]         r_rr_ptr;
  logic [NUM_WBPORT-1:0] r_wb_vld;
  valwbInfo_t            r_wbInfo [NUM_WBPORT];
  logic [CNT_W-1:0]      r_conflict_cnt;

  logic [NUM_FU-1:0]     w_grant;
  logic [NUM_WBPORT-1:0] w_port_vld;
  logic [IW-1:0]         w_port_idx [NUM_WBPORT];
  logic [IW-1:0]         w_last_idx;
  valwbInfo_t            w_nxt_info [NUM_WBPORT];
  int                    w_req_cnt;

  wb_rr_picker #(
    .NUM_FU     (NUM_FU),
    .NUM_WBPORT (NUM_WBPORT),
    .IW         (IW)
  ) u_picker (
    .i_req      (bus.i_fu_wb_vld),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_port_vld (w_port_vld),
    .o_port_idx (w_port_idx),
    .o_last_idx (w_last_idx)
  );

  always_comb begin
    w_req_cnt = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.i_fu_wb_vld[i]) w_req_cnt = w_req_cnt + 1;
    end
  end

  // Ungranted ports carry whatever payload is muxed in, but never a write enable.
  always_comb begin
    for (int k = 0; k < NUM_WBPORT; k++) begin
      w_nxt_info[k]        = bus.i_fu_wbInfo[w_port_idx[k]];
      w_nxt_info[k].rd_wen = w_port_vld[k] & bus.i_fu_wbInfo[w_port_idx[k]].rd_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr       <= '0;
      r_wb_vld       <= '0;
      r_conflict_cnt <= '0;
      for (int k = 0; k < NUM_WBPORT; k++) r_wbInfo[k] <= '0;
    end else begin
      if (|w_grant) r_rr_ptr <= IW'(wrap_add(int'(w_last_idx), 1, NUM_FU));
      r_wb_vld <= w_port_vld;
      for (int k = 0; k < NUM_WBPORT; k++) r_wbInfo[k] <= w_nxt_info[k];
      if (w_req_cnt > NUM_WBPORT) r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.o_fu_wb_stall  = rst ? (bus.i_fu_wb_vld & ~w_grant) : '1;
  assign bus.o_wb_vld       = r_wb_vld;
  assign bus.o_wbInfo       = r_wbInfo;
  assign bus.o_conflict_cnt = r_conflict_cnt;

endmodule
